fw_drop_stage: RTL

- Stage directly downstream of the header-parsing firewall in the user data path.
- Buffers each packet word stream in a packet FIFO and pairs every packet, in arrival order, with a one-bit verdict from a separate verdict FIFO.
- Forwards the whole packet on the output bus, or silently discards it, depending on that verdict.
- Keeps forwarded/dropped packet counters.

---
 rtl/fw_drop_stage_pkg.sv | 44 ++++
 rtl/fallthrough_small_fifo.sv | 63 ++++++
 rtl/fw_drop_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fw_drop_stage_pkg.sv
// Shared definitions for the firewall drop stage: FSM state encodings and
// the helpers that classify a word by its ctrl field.
package fw_drop_stage_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FWD_HDR  = 3'd1,
        ST_FWD_PAY  = 3'd2,
        ST_DROP_HDR = 3'd3,
        ST_DROP_PAY = 3'd4
    } state_t;

    // Verdict bit value meaning "discard this packet".
    localparam logic VERDICT_DROP = 1'b1;

    // State after a word with the given ctrl classification has moved.
    // Header states leave on the first ctrl==0 word; payload states end the
    // packet on the first ctrl!=0 word.
    function automatic state_t advance(input state_t s, input logic ctrl_nz);
        state_t r;
        r = s;
        case (s)
            ST_FWD_HDR:  r = ctrl_nz ? ST_FWD_HDR  : ST_FWD_PAY;
            ST_FWD_PAY:  r = ctrl_nz ? ST_IDLE     : ST_FWD_PAY;
            ST_DROP_HDR: r = ctrl_nz ? ST_DROP_HDR : ST_DROP_PAY;
            ST_DROP_PAY: r = ctrl_nz ? ST_IDLE     : ST_DROP_PAY;
            default:     r = ST_IDLE;
        endcase
        return r;
    endfunction

    // True when the moving word closes the packet.
    function automatic logic is_eop(input state_t s, input logic ctrl_nz);
        logic r;
        r = 1'b0;
        case (s)
            ST_FWD_PAY:  r = ctrl_nz;
            ST_DROP_PAY: r = ctrl_nz;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head entry is visible on dout
// the cycle after it is written, and rd_en consumes it.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0]   DEPTH_C = {1'b1, {MAX_DEPTH_BITS{1'b0}}};
    localparam logic [MAX_DEPTH_BITS:0]   NFULL_C = {1'b0, {MAX_DEPTH_BITS{1'b1}}};
    localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE = (MAX_DEPTH_BITS+1)'(1'b1);
    localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE = MAX_DEPTH_BITS'(1'b1);

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [MAX_DEPTH_BITS:0]   count_q;
    logic                      wr_ok_s, rd_ok_s;

    assign wr_ok_s     = wr_en && (count_q != DEPTH_C);
    assign rd_ok_s     = rd_en && (count_q != '0);
    assign dout        = mem_q[rd_ptr_q];
    assign empty       = (count_q == '0);
    // One slot of slack so a writer sampling this flag cannot overflow.
    assign nearly_full = (count_q >= NFULL_C);

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fw_drop_stage.sv
// Firewall drop stage: pairs each buffered packet with its verdict in
// arrival order, then forwards or silently discards the whole packet.
module fw_drop_stage
    import fw_drop_stage_pkg::*;
#(
    parameter int DATA_WIDTH              = 64,
    parameter int CTRL_WIDTH              = DATA_WIDTH / 8,
    parameter int PKT_FIFO_DEPTH_BITS     = 8,
    parameter int VERDICT_FIFO_DEPTH_BITS = 2,
    parameter int CNT_WIDTH               = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    input  logic                  verdict_vld,
    input  logic                  verdict_drop,
    output logic                  verdict_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic [CNT_WIDTH-1:0]  pkts_fwd,
    output logic [CNT_WIDTH-1:0]  pkts_drop
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);

    logic                  pkt_empty_s, pkt_nf_s, pkt_rd_s;
    logic                  vd_dout_s, vd_empty_s, vd_nf_s, vd_rd_s;
    logic                  ctrl_nz_s;
    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  fwd_q, fwd_d, drop_q, drop_d;

    fallthrough_small_fifo #(
        .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
        .MAX_DEPTH_BITS (PKT_FIFO_DEPTH_BITS)
    ) u_pkt_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (pkt_rd_s),
        .dout        ({out_ctrl, out_data}),
        .nearly_full (pkt_nf_s),
        .empty       (pkt_empty_s)
    );

    fallthrough_small_fifo #(
        .WIDTH          (1),
        .MAX_DEPTH_BITS (VERDICT_FIFO_DEPTH_BITS)
    ) u_verdict_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .din         (verdict_drop),
        .wr_en       (verdict_vld),
        .rd_en       (vd_rd_s),
        .dout        (vd_dout_s),
        .nearly_full (vd_nf_s),
        .empty       (vd_empty_s)
    );

    assign in_rdy      = !pkt_nf_s;
    assign verdict_rdy = !vd_nf_s;
    assign ctrl_nz_s   = (out_ctrl != '0);
    assign pkts_fwd    = fwd_q;
    assign pkts_drop   = drop_q;

    // Next-state, FIFO pops, output strobe and counter increments.
    always_comb begin
        state_d  = state_q;
        pkt_rd_s = 1'b0;
        vd_rd_s  = 1'b0;
        out_wr   = 1'b0;
        fwd_d    = fwd_q;
        drop_d   = drop_q;
        case (state_q)
            ST_IDLE: begin
                // Claim a verdict only once its packet has started arriving.
                if (!vd_empty_s && !pkt_empty_s) begin
                    vd_rd_s = 1'b1;
                    state_d = (vd_dout_s == VERDICT_DROP) ? ST_DROP_HDR : ST_FWD_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FWD_HDR, ST_FWD_PAY: begin
                if (!pkt_empty_s && out_rdy) begin
                    out_wr   = 1'b1;
                    pkt_rd_s = 1'b1;
                    state_d  = advance(state_q, ctrl_nz_s);
                    if (is_eop(state_q, ctrl_nz_s)) begin
                        fwd_d = fwd_q + CNT_ONE;
                    end else begin
                        fwd_d = fwd_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DROP_HDR, ST_DROP_PAY: begin
                // Discarded words ignore downstream backpressure.
                if (!pkt_empty_s) begin
                    pkt_rd_s = 1'b1;
                    state_d  = advance(state_q, ctrl_nz_s);
                    if (is_eop(state_q, ctrl_nz_s)) begin
                        drop_d = drop_q + CNT_ONE;
                    end else begin
                        drop_d = drop_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and packet counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            fwd_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            fwd_q   <= fwd_d;
            drop_q  <= drop_d;
        end
    end

endmodule
